// File: rtl/graph_lut_unary_ctrl_if.sv
// graph_lut_unary_ctrl_if: command, SRAM, LUT and status bundle for the LUT unary-op controller
interface graph_lut_unary_ctrl_if #(
  parameter int ADDR_W = 16,
  parameter int LEN_W  = 16
);
  logic              cmd_valid;
  logic              cmd_ready;
  logic [ADDR_W-1:0] cmd_src_base;
  logic [ADDR_W-1:0] cmd_dst_base;
  logic [LEN_W-1:0]  cmd_len;
  logic              rd_en;
  logic [ADDR_W-1:0] rd_addr;
  logic [7:0]        rd_data;
  logic [7:0]        lut_addr;
  logic [7:0]        lut_data;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [7:0]        wr_data;
  logic              busy;
  logic              done;
  modport slave (
    input  cmd_valid, cmd_src_base, cmd_dst_base, cmd_len, rd_data, lut_data,
    output cmd_ready, rd_en, rd_addr, lut_addr, wr_en, wr_addr, wr_data, busy, done
  );
  modport master (
    output cmd_valid, cmd_src_base, cmd_dst_base, cmd_len, rd_data, lut_data,
    input  cmd_ready, rd_en, rd_addr, lut_addr, wr_en, wr_addr, wr_data, busy, done
  );
endinterface

// File: rtl/graph_lut_unary_ctrl.sv
// graph_lut_unary_ctrl: streams a tensor through a shared LUT ROM, 1 element/cycle; optional perf counter via GRAPH_LUT_CTRL_PERF_EN
module graph_lut_unary_ctrl #(
  parameter int ADDR_W = 16,
  parameter int LEN_W  = 16
) (
  input  logic clk,
  input  logic rst,
`ifdef GRAPH_LUT_CTRL_PERF_EN
  output logic [31:0] perf_cycles,
`endif
  graph_lut_unary_ctrl_if.slave bus
);
  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} state_t;
  localparam logic [LEN_W-1:0] ONE = 1;
  state_t            state_q, state_d;
  logic [ADDR_W-1:0] src_q, src_d, dst_q, dst_d;
  logic [LEN_W-1:0]  len_q, len_d, idx_q, idx_d;
  logic              s1_v_q, s2_v_q;
  logic [ADDR_W-1:0] s1_a_q, s2_a_q;
  logic              accept;
  assign accept        = bus.cmd_valid && bus.cmd_ready;
  assign bus.cmd_ready = state_q == IDLE && !rst;
  assign bus.rd_en     = state_q == ISSUE;
  assign bus.rd_addr   = bus.rd_en ? src_q + ADDR_W'(idx_q) : '0;
  assign bus.lut_addr  = bus.rd_data;
  assign bus.wr_en     = s2_v_q;
  assign bus.wr_addr   = s2_v_q ? s2_a_q : '0;
  assign bus.wr_data   = bus.lut_data;
  assign bus.busy      = state_q != IDLE;
  assign bus.done      = state_q == DONE;
  // Next state and command latching; DRAIN exits once stage1 is empty, since stage2 then empties on the same edge
  always_comb begin
    state_d = state_q;
    src_d   = src_q;
    dst_d   = dst_q;
    len_d   = len_q;
    idx_d   = idx_q;
    case (state_q)
      IDLE: if (accept) begin
        src_d   = bus.cmd_src_base;
        dst_d   = bus.cmd_dst_base;
        len_d   = bus.cmd_len;
        idx_d   = '0;
        state_d = bus.cmd_len == '0 ? DONE : ISSUE;
      end
      ISSUE: begin
        idx_d   = idx_q + ONE;
        state_d = idx_q == len_q - ONE ? DRAIN : ISSUE;
      end
      DRAIN:   state_d = s1_v_q ? DRAIN : DONE;
      default: state_d = IDLE;
    endcase
  end
  // FSM and command registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      src_q   <= '0;
      dst_q   <= '0;
      len_q   <= '0;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      src_q   <= src_d;
      dst_q   <= dst_d;
      len_q   <= len_d;
      idx_q   <= idx_d;
    end
  end
  // Two-stage in-flight pipe matching SRAM read latency plus registered LUT output
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_v_q <= 1'b0;
      s2_v_q <= 1'b0;
      s1_a_q <= '0;
      s2_a_q <= '0;
    end else begin
      s1_v_q <= bus.rd_en;
      s2_v_q <= s1_v_q;
      s1_a_q <= dst_q + ADDR_W'(idx_q);
      s2_a_q <= s1_a_q;
    end
  end
`ifdef GRAPH_LUT_CTRL_PERF_EN
  logic [31:0] perf_q;
  assign perf_cycles = perf_q;
  // Busy-cycle counter, cleared per command, saturating, frozen in IDLE
  always_ff @(posedge clk) begin
    if (rst || accept) perf_q <= '0;
    else if (bus.busy && perf_q != 32'hFFFF_FFFF) perf_q <= perf_q + 32'd1;
  end
`endif
endmodule

// File: tb/tb_graph_lut_unary_ctrl.sv
// tb_graph_lut_unary_ctrl: scoreboard bench with SRAM and SQRT LUT models
module tb_graph_lut_unary_ctrl;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;
  graph_lut_unary_ctrl_if #(.ADDR_W(16), .LEN_W(16)) bus ();
`ifdef GRAPH_LUT_CTRL_PERF_EN
  logic [31:0] perf_cycles;
`endif
  graph_lut_unary_ctrl #(.ADDR_W(16), .LEN_W(16)) dut (
    .clk(clk),
    .rst(rst),
`ifdef GRAPH_LUT_CTRL_PERF_EN
    .perf_cycles(perf_cycles),
`endif
    .bus(bus)
  );
  logic [7:0]  mem [65536];
  logic [7:0]  lut [256];
  logic [15:0] rd_q[$];
  logic [15:0] wa_q[$];
  logic [7:0]  wd_q[$];
  int checks = 0;
  int failures = 0;
  int rd_cnt = 0;
  int wr_cnt = 0;
  int busy_cnt = 0;
  int cyc;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask
  always @(posedge clk) begin
    if (bus.rd_en) bus.rd_data <= mem[bus.rd_addr];
    if (bus.wr_en) mem[bus.wr_addr] <= bus.wr_data;
    bus.lut_data <= lut[bus.lut_addr];
  end
  always @(negedge clk) begin
    if (!rst) begin
      if (bus.busy) busy_cnt++;
      if (bus.rd_en) begin
        rd_cnt++;
        if (rd_q.size() == 0) chk("rd_unexpected", 1, 0);
        else chk("rd_addr", {16'd0, bus.rd_addr}, {16'd0, rd_q.pop_front()});
      end
      if (bus.wr_en) begin
        wr_cnt++;
        if (wa_q.size() == 0) chk("wr_unexpected", 1, 0);
        else begin
          chk("wr_addr", {16'd0, bus.wr_addr}, {16'd0, wa_q.pop_front()});
          chk("wr_data", {24'd0, bus.wr_data}, {24'd0, wd_q.pop_front()});
        end
      end
    end
  end
  task automatic expect_cmd(input logic [15:0] src, input logic [15:0] dst, input int len);
    for (int i = 0; i < len; i++) begin
      logic [15:0] sa;
      logic [15:0] da;
      sa = src + 16'(i);
      da = dst + 16'(i);
      rd_q.push_back(sa);
      wa_q.push_back(da);
      wd_q.push_back(lut[mem[sa]]);
    end
  endtask
  task automatic wait_done(output int c);
    c = 1;
    while (!bus.done && c < 300) begin
      @(negedge clk);
      c++;
    end
  endtask
  task automatic run(input logic [15:0] src, input logic [15:0] dst, input int len);
    int exp_cyc;
    exp_cyc = len == 0 ? 1 : len + 3;
    @(negedge clk);
    rd_cnt = 0;
    wr_cnt = 0;
    busy_cnt = 0;
    chk("ready_before", {31'd0, bus.cmd_ready}, 1);
    bus.cmd_src_base = src;
    bus.cmd_dst_base = dst;
    bus.cmd_len = 16'(len);
    bus.cmd_valid = 1'b1;
    expect_cmd(src, dst, len);
    @(negedge clk);
    bus.cmd_valid = 1'b0;
    wait_done(cyc);
    chk("done_cycle", cyc, exp_cyc);
    @(negedge clk);
    chk("done_pulse", {31'd0, bus.done}, 0);
    chk("idle_busy", {31'd0, bus.busy}, 0);
    chk("ready_after", {31'd0, bus.cmd_ready}, 1);
    chk("sb_empty", rd_q.size() + wa_q.size(), 0);
`ifdef GRAPH_LUT_CTRL_PERF_EN
    chk("perf", perf_cycles, exp_cyc);
`endif
  endtask
  initial begin
    logic [7:0] t1 [4];
    logic [7:0] t2 [3];
    int snap;
    t1 = '{8'h00, 8'h20, 8'h2D, 8'h40};
    t2 = '{8'h00, 8'h00, 8'h06};
    for (int i = 0; i < 256; i++) lut[i] = i >= 128 ? 8'h00 : 8'($rtoi($sqrt(32.0 * i) + 0.5));
    for (int i = 0; i < 65536; i++) mem[i] = 8'($urandom);
    bus.cmd_valid = 1'b0;
    bus.cmd_src_base = '0;
    bus.cmd_dst_base = '0;
    bus.cmd_len = '0;
    repeat (2) @(negedge clk);
    chk("rst_ready", {31'd0, bus.cmd_ready}, 0);
    chk("rst_rd_en", {31'd0, bus.rd_en}, 0);
    chk("rst_busy", {31'd0, bus.busy}, 0);
    rst = 1'b0;
    @(negedge clk);
    chk("idle_ready", {31'd0, bus.cmd_ready}, 1);
    chk("idle_wr_en", {31'd0, bus.wr_en}, 0);
    chk("idle_done", {31'd0, bus.done}, 0);
    chk("idle_rd_addr", {16'd0, bus.rd_addr}, 0);
    chk("idle_wr_addr", {16'd0, bus.wr_addr}, 0);
    mem[16'h0100] = 8'h00; mem[16'h0101] = 8'h20; mem[16'h0102] = 8'h40; mem[16'h0103] = 8'h7F;
    run(16'h0100, 16'h0200, 4);
    for (int i = 0; i < 4; i++) chk("t1_mem", {24'd0, mem[16'h0200 + 16'(i)]}, {24'd0, t1[i]});
    mem[16'h0010] = 8'h80; mem[16'h0011] = 8'hFF; mem[16'h0012] = 8'h01;
    run(16'h0010, 16'h0010, 3);
    for (int i = 0; i < 3; i++) chk("t2_mem", {24'd0, mem[16'h0010 + 16'(i)]}, {24'd0, t2[i]});
    chk("t2_wr_cnt", wr_cnt, 3);
    run(16'h0020, 16'h0030, 0);
    chk("t3_rd_cnt", rd_cnt, 0);
    chk("t3_wr_cnt", wr_cnt, 0);
    chk("t3_busy_cnt", busy_cnt, 1);
    run(16'hFFFE, 16'hFFFD, 4);
    chk("t4_rd_cnt", rd_cnt, 4);
    run(16'h1234, 16'h4000, 20);
    @(negedge clk);
    bus.cmd_src_base = 16'h0300;
    bus.cmd_dst_base = 16'h0400;
    bus.cmd_len = 16'd16;
    bus.cmd_valid = 1'b1;
    expect_cmd(16'h0300, 16'h0400, 16);
    @(negedge clk);
    bus.cmd_valid = 1'b0;
    repeat (4) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("t5_rd_en", {31'd0, bus.rd_en}, 0);
    chk("t5_wr_en", {31'd0, bus.wr_en}, 0);
    chk("t5_busy", {31'd0, bus.busy}, 0);
    chk("t5_done", {31'd0, bus.done}, 0);
    chk("t5_addrs", {bus.rd_addr, bus.wr_addr}, 0);
    rd_q.delete();
    wa_q.delete();
    wd_q.delete();
    rst = 1'b0;
    snap = wr_cnt;
    repeat (5) @(negedge clk);
    chk("t5_no_wr", wr_cnt, snap);
    run(16'h0500, 16'h0300, 2);
    @(negedge clk);
    bus.cmd_src_base = 16'h0600;
    bus.cmd_dst_base = 16'h0700;
    bus.cmd_len = 16'd8;
    bus.cmd_valid = 1'b1;
    expect_cmd(16'h0600, 16'h0700, 8);
    @(negedge clk);
    bus.cmd_src_base = 16'h0800;
    bus.cmd_dst_base = 16'h0880;
    bus.cmd_len = 16'd5;
    cyc = 1;
    while (!bus.cmd_ready && cyc < 100) begin
      @(negedge clk);
      cyc++;
    end
    chk("t6_accept_cycle", cyc, 12);
`ifdef GRAPH_LUT_CTRL_PERF_EN
    chk("t6_perf", perf_cycles, 11);
`endif
    expect_cmd(16'h0800, 16'h0880, 5);
    @(negedge clk);
    bus.cmd_valid = 1'b0;
    wait_done(cyc);
    chk("t6_second_done", cyc, 8);
    @(negedge clk);
    chk("t6_sb_empty", rd_q.size() + wa_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
